// File: rtl/fft_sipo_pkg.sv
// Shared types and helpers for the flexible SIPO collector feeding the RX FFT.
package fft_sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  localparam int unsigned SHIFT_LENGTH_DEF = 12;
  localparam int unsigned CNT_W            = $clog2(SHIFT_LENGTH_DEF) + 1;

  // Zero or oversize requests collect a full-depth frame.
  function automatic int unsigned clamp_limit(input int unsigned limit,
                                              input int unsigned max_len);
    return ((limit == 0) || (limit > max_len)) ? max_len : limit;
  endfunction

endpackage

// File: rtl/flexsipo_ctrl.sv
// Frame controller: FSM, sample counter, latched limit, done/overrun flags, write decode.
// Optional back-to-back collection when FLEXSIPO_AUTO_REARM_EN is defined.
module flexsipo_ctrl
  import fft_sipo_pkg::*;
#(
  parameter int SHIFT_LENGTH = 12,
  parameter int LIM_W        = $clog2(SHIFT_LENGTH) + 1,
  parameter int IDX_W        = (SHIFT_LENGTH > 1) ? $clog2(SHIFT_LENGTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LIM_W-1:0] i_limit,
  input  logic             i_valid,
  input  logic             i_ack,
  output logic             o_ready,
  output logic             o_pvalid,
  output logic             o_done,
  output logic [LIM_W-1:0] o_count,
  output logic             o_overrun,
  output logic             o_wr_en,
  output logic [IDX_W-1:0] o_wr_idx,
  output logic             o_clear
);

  state_t           state_q, state_d;
  logic [LIM_W-1:0] lim_q;
  logic [LIM_W-1:0] cnt_inc;
  logic             done_q;
  logic             overrun_q;

  assign cnt_inc  = o_count + LIM_W'(1);
  assign o_wr_idx = IDX_W'(SHIFT_LENGTH - 1) - IDX_W'(o_count);
  assign o_done   = done_q;
  assign o_overrun = overrun_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_start) state_d = ST_FILL;
      ST_FILL: begin
        if (i_start)                             state_d = ST_FILL;
        else if (i_valid && (cnt_inc == lim_q))  state_d = ST_FULL;
      end
      ST_FULL: begin
        if (i_start) state_d = ST_FILL;
        else if (i_ack) begin
`ifdef FLEXSIPO_AUTO_REARM_EN
          state_d = ST_FILL;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready  = 1'b0;
    o_pvalid = 1'b0;
    o_wr_en  = 1'b0;
    o_clear  = i_start;
    case (state_q)
      ST_FILL: begin
        o_ready = 1'b1;
        o_wr_en = i_valid && !i_start;
      end
      ST_FULL: begin
        o_pvalid = 1'b1;
`ifdef FLEXSIPO_AUTO_REARM_EN
        o_clear  = i_start || i_ack;
`endif
      end
      default: ;
    endcase
  end

  // Counter, limit latch and status flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count   <= '0;
      lim_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= o_wr_en && (cnt_inc == lim_q);
      if (i_start) begin
        lim_q     <= LIM_W'(clamp_limit(32'(i_limit), SHIFT_LENGTH));
        o_count   <= '0;
        overrun_q <= 1'b0;
      end else begin
        if (o_wr_en)                          o_count <= cnt_inc;
        else if ((state_q == ST_FULL) && i_ack) o_count <= '0;
        if (i_valid && !o_ready)              overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/flexsipo_fft.sv
// Flexible serial-in/parallel-out frame collector; sample k lands at index SHIFT_LENGTH-1-k.
// Build option FLEXSIPO_AUTO_REARM_EN re-arms collection on i_ack (see flexsipo_ctrl).
module flexsipo_fft
  import fft_sipo_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int SHIFT_LENGTH = 12,
  parameter int IS_COMP      = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [$clog2(SHIFT_LENGTH):0] i_limit,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_sin  [0:IS_COMP],
  input  logic                         i_ack,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_pout [0:SHIFT_LENGTH-1][0:IS_COMP],
  output logic                         o_pvalid,
  output logic                         o_done,
  output logic [$clog2(SHIFT_LENGTH):0] o_count,
  output logic                         o_overrun
);

  localparam int LIM_W = $clog2(SHIFT_LENGTH) + 1;
  localparam int IDX_W = (SHIFT_LENGTH > 1) ? $clog2(SHIFT_LENGTH) : 1;

  logic             wr_en;
  logic             clear;
  logic [IDX_W-1:0] wr_idx;

  flexsipo_ctrl #(
    .SHIFT_LENGTH (SHIFT_LENGTH),
    .LIM_W        (LIM_W),
    .IDX_W        (IDX_W)
  ) u_ctrl (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_limit   (i_limit),
    .i_valid   (i_valid),
    .i_ack     (i_ack),
    .o_ready   (o_ready),
    .o_pvalid  (o_pvalid),
    .o_done    (o_done),
    .o_count   (o_count),
    .o_overrun (o_overrun),
    .o_wr_en   (wr_en),
    .o_wr_idx  (wr_idx),
    .o_clear   (clear)
  );

  // Frame buffer: samples pass through bit-exact, unwritten slots stay zero
  for (genvar i = 0; i < SHIFT_LENGTH; i++) begin : g_slot
    for (genvar j = 0; j <= IS_COMP; j++) begin : g_comp
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                              o_pout[i][j] <= '0;
        else if (clear)                            o_pout[i][j] <= '0;
        else if (wr_en && (wr_idx == IDX_W'(i)))   o_pout[i][j] <= i_sin[j];
      end
    end
  end

endmodule

// File: tb/tb_flexsipo_fft.sv
// Scoreboard bench for flexsipo_fft: stimulus pushes expected frames, a monitor checks on o_done.
module tb_flexsipo_fft;

  localparam int DW = 16;
  localparam int SL = 12;

  typedef struct {
    logic signed [DW-1:0] i [SL];
    logic signed [DW-1:0] q [SL];
    int                   cnt;
  } frame_t;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_start = 1'b0;
  logic [4:0]           i_limit = '0;
  logic                 i_valid = 1'b0;
  logic signed [DW-1:0] sin  [0:1];
  logic                 i_ack = 1'b0;
  logic                 o_ready, o_pvalid, o_done, o_overrun;
  logic [4:0]           o_count;
  logic signed [DW-1:0] pout [0:SL-1][0:1];

  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_done   = 0;
  int     n_pushed = 0;
  frame_t exp_q[$];
  frame_t last_exp;
  frame_t zero_f;

  flexsipo_fft #(.DATA_WIDTH(DW), .SHIFT_LENGTH(SL), .IS_COMP(1)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .i_limit   (i_limit),
    .i_valid   (i_valid),
    .i_sin     (sin),
    .i_ack     (i_ack),
    .o_ready   (o_ready),
    .o_pout    (pout),
    .o_pvalid  (o_pvalid),
    .o_done    (o_done),
    .o_count   (o_count),
    .o_overrun (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_frame(input string name, input frame_t f);
    for (int k = 0; k < SL; k++) begin
      chk($sformatf("%s_I[%0d]", name, k), pout[k][0], f.i[k]);
      chk($sformatf("%s_Q[%0d]", name, k), pout[k][1], f.q[k]);
    end
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic start(input int lim);
    i_start = 1'b1;
    i_limit = 5'(lim);
    cyc();
    i_start = 1'b0;
  endtask

  task automatic send(input int iv, input int qv);
    i_valid = 1'b1;
    sin[0]  = 16'(iv);
    sin[1]  = 16'(qv);
    cyc();
    i_valid = 1'b0;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
  endtask

  // Sends a frame of n samples (I=ib+k, Q=qb-k), optionally with idle gaps, and queues its image.
  task automatic run_frame(input int n, input int ib, input int qb, input bit gaps);
    frame_t f;
    f = zero_f;
    for (int k = 0; k < n; k++) begin
      f.i[SL-1-k] = 16'(ib + k);
      f.q[SL-1-k] = 16'(qb - k);
      if (gaps && (k % 3 == 1)) begin
        cyc();
        cyc();
      end
      if (k == n - 1) begin
        chk("pre_last_pvalid", o_pvalid, 0);
        chk("pre_last_count", o_count, n - 1);
      end
      send(ib + k, qb - k);
    end
    f.cnt = n;
    exp_q.push_back(f);
    last_exp = f;
    n_pushed++;
  endtask

  // Monitor: every o_done must match the oldest queued frame
  initial begin
    bit prev_done;
    frame_t f;
    prev_done = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_rst_n && o_done) begin
        n_done++;
        chk("done_width", prev_done, 0);
        chk("done_pvalid", o_pvalid, 1);
        if (exp_q.size() == 0) begin
          chk("done_without_frame", o_done, 0);
        end else begin
          f = exp_q.pop_front();
          cmp_frame("frame", f);
          chk("frame_count", o_count, f.cnt);
        end
      end
      prev_done = o_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < SL; k++) begin
      zero_f.i[k] = '0;
      zero_f.q[k] = '0;
    end
    zero_f.cnt = 0;
    last_exp = zero_f;
    sin[0] = '0;
    sin[1] = '0;

    // Reset state
    repeat (3) cyc();
    chk("rst_ready", o_ready, 0);
    chk("rst_pvalid", o_pvalid, 0);
    chk("rst_done", o_done, 0);
    chk("rst_count", o_count, 0);
    chk("rst_overrun", o_overrun, 0);
    cmp_frame("rst_buf", zero_f);
    i_rst_n = 1'b1;
    cyc();
    chk("idle_ready", o_ready, 0);

    // Full frame, I=k Q=-k
    start(12);
    chk("t1_ready", o_ready, 1);
    chk("t1_count0", o_count, 0);
    run_frame(12, 0, 0, 1'b0);
    chk("t1_full_ready", o_ready, 0);
    chk("t1_full_pvalid", o_pvalid, 1);
    repeat (3) cyc();
    chk("t1_done_low", o_done, 0);
    chk("t1_hold_pvalid", o_pvalid, 1);
    cmp_frame("t1_hold", last_exp);
    ack();
    chk("t1_ack_pvalid", o_pvalid, 0);
    chk("t1_ack_ready", o_ready, 0);
    chk("t1_ack_count", o_count, 0);
    cmp_frame("t1_keep", last_exp);

    // Short frame; then a stray sample in IDLE
    start(5);
    run_frame(5, 100, -100, 1'b0);
    chk("t2_count", o_count, 5);
    chk("t2_pvalid", o_pvalid, 1);
    ack();
    send(9, 9);
    chk("idle_overrun", o_overrun, 1);

    // Clamp: limit 0 and limit 15 both collect 12, second with gaps
    start(0);
    chk("t3_overrun_clr", o_overrun, 0);
    run_frame(12, 1000, 50, 1'b0);
    ack();
    start(15);
    run_frame(12, -300, 7, 1'b1);
    chk("t3_count", o_count, 12);

    // Overrun in FULL leaves the buffer intact
    send(7, 7);
    chk("t4_overrun", o_overrun, 1);
    chk("t4_pvalid", o_pvalid, 1);
    cmp_frame("t4_unchanged", last_exp);

    // Start from FULL, then abort after 3 samples with a dropped sample on the start cycle
    start(6);
    chk("t4_overrun_clr", o_overrun, 0);
    chk("t5_full_start_pvalid", o_pvalid, 0);
    chk("t5_full_start_ready", o_ready, 1);
    cmp_frame("t5_cleared", zero_f);
    send(1, 1);
    send(2, 2);
    send(3, 3);
    chk("t5_count3", o_count, 3);
    i_valid = 1'b1;
    sin[0] = 16'sd555;
    sin[1] = 16'sd555;
    start(4);
    i_valid = 1'b0;
    chk("t5_abort_count", o_count, 0);
    cmp_frame("t5_abort_buf", zero_f);
    run_frame(4, 20, -20, 1'b0);
    ack();

    // Asynchronous reset mid-frame: no done, everything cleared
    start(12);
    send(11, 11);
    send(12, 12);
    send(13, 13);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_count", o_count, 0);
    chk("t6_rst_ready", o_ready, 0);
    chk("t6_rst_pvalid", o_pvalid, 0);
    chk("t6_rst_done", o_done, 0);
    cmp_frame("t6_rst_buf", zero_f);
    repeat (3) cyc();
    i_rst_n = 1'b1;
    repeat (2) cyc();
    chk("t6_post_ready", o_ready, 0);

    // Behaviour of i_ack in FULL
    start(3);
    run_frame(3, 40, 60, 1'b0);
    ack();
`ifdef FLEXSIPO_AUTO_REARM_EN
    chk("rearm_ready", o_ready, 1);
    chk("rearm_count", o_count, 0);
    cmp_frame("rearm_buf", zero_f);
    run_frame(3, 70, 80, 1'b0);
    chk("rearm_pvalid", o_pvalid, 1);
    ack();
`else
    chk("ack_idle_ready", o_ready, 0);
    chk("ack_idle_pvalid", o_pvalid, 0);
    cmp_frame("ack_keep", last_exp);
`endif
    repeat (3) cyc();

    chk("frames_done", n_done, n_pushed);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
